xbar_port_arbiter: RTL and testbench
====================================

// Module: xbar_port_arbiter
// PURPOSE
//  Per-output round-robin allocator that drives the fifo_sel_bits_0..3 inputs of the 4x4 AXIS cross bar.
//  Each rx port requests one destination FIFO (0..3).
//  The arbiter grants at most one rx port per FIFO and at most one FIFO per rx port.
//  It holds the grant until the owner's tlast beat is accepted, then frees the FIFO; a watchdog frees stalled grants.
// PARAMETERS
//  TIMEOUT  1024  consecutive owner cycles with no accepted beat before forced release; 0 = watchdog off
//  TO_W     11    counter width; must hold TIMEOUT (>= clog2(TIMEOUT+1))
// PORTS
//  glb_clk          in   1  single clock, all logic rising-edge
//  glb_reset        in   1  synchronous reset, active-high
//  rx_req           in   4  bit i: rx port i requests a FIFO; held until rx_grant[i] is seen
//  rx_dest          in   8  [2i+1:2i] = destination FIFO index of rx port i; valid while rx_req[i]
//  rx_tvalid        in   4  rx_s_axis_i_tvalid, observed only
//  rx_tready        in   4  rx_s_axis_i_tready (cross bar output), observed only
//  rx_tlast         in   4  rx_s_axis_i_tlast, observed only
//  cfg_out_en       in   4  bit j: FIFO j may accept new grants
//  fifo_sel_bits_0  out  4  one-hot owner rx port of FIFO 0; 4'b0000 = idle
//  fifo_sel_bits_1  out  4  same, FIFO 1
//  fifo_sel_bits_2  out  4  same, FIFO 2
//  fifo_sel_bits_3  out  4  same, FIFO 3
//  rx_grant         out  4  bit i: rx port i currently owns a FIFO (OR of column i of all sel vectors)
//  out_busy         out  4  bit j: FIFO j owned (|fifo_sel_bits_j)
//  timeout_err      out  4  bit j: 1-cycle pulse, FIFO j force-released by watchdog
// BEHAVIOUR
//  Reset:
//   - All outputs are 0.
//   - All round-robin pointers are 0 and all watchdog counters are 0.
//   - Reset asserted mid-packet clears every grant at that edge; no err pulse.
//  Per-FIFO state machine:
//   - States are IDLE and OWNED; the owner is held in a registered one-hot vector.
//   - Candidates in IDLE: rx ports with rx_req=1, rx_dest=j, rx_grant=0 and cfg_out_en[j]=1.
//   - Winner: first candidate found searching upward from ptr_j, wrapping 3->0.
//   - At the next edge, fifo_sel_bits_j = onehot(winner), ptr_j = winner+1 mod 4, state becomes OWNED.
//   - Grant latency is 1 cycle from the cycle rx_req is first visible.
//  One FIFO per rx port:
//   - A port already granted is never a candidate.
//   - Each rx port requests one rx_dest, so two FIFOs can never pick the same port in the same cycle.
//  Release:
//   - In OWNED with owner i, rx_tvalid[i]&rx_tready[i]&rx_tlast[i] causes the next edge to clear sel, go IDLE, zero the counter.
//   - A new grant to FIFO j is possible at the following edge, so sel is 0 for at least 1 cycle between packets.
//  Watchdog (TIMEOUT>0):
//   - The counter increments each OWNED cycle with no owner handshake and clears on any owner handshake.
//   - When the counter reaches TIMEOUT-1 with no handshake, the next edge releases the FIFO and pulses timeout_err[j] for 1 cycle.
//   - A tlast handshake in that same cycle is a normal release with no err.
//  Disabling:
//   - Clearing cfg_out_en[j] while OWNED does not abort the packet; it only blocks new grants.
//  Request rules:
//   - rx_dest is sampled only at grant; changes while granted are ignored.
//   - rx_req seen with rx_grant[i]=1 is ignored until release.
//  Independence:
//   - All four FIFOs arbitrate in parallel in the same cycle.
//   - Outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  T1 reset:
//   - Assert glb_reset 2 cycles with rx_req=4'hF.
//   - Expect all sel/rx_grant/out_busy/timeout_err = 0; first grant 1 cycle after deassert.
//  T2 single packet:
//   - Stimulus: rx_req[2]=1, dest=1, 3 beats (tlast on 3rd).
//   - Expect fifo_sel_bits_1=4'b0100 and rx_grant=4'b0100 1 cycle after req.
//   - Expect sel=0 the edge after the tlast beat.
//  T3 round-robin:
//   - Stimulus: ports 0,1,3 request dest 0 continuously, 1-beat packets.
//   - Expect grant order 0,1,3,0,1.
//   - Expect 1 idle cycle between grants.
//  T4 parallel:
//   - Stimulus: port0->dest2 and port1->dest3 in the same cycle.
//   - Expect sel_2=4'b0001 and sel_3=4'b0010 at the same edge.
//   - Expect cfg_out_en[3]=0 to block port1 instead.
//  T5 watchdog:
//   - Stimulus: TIMEOUT=8, grant port 3 on dest 0, hold rx_tvalid[3]=0.
//   - Expect sel_0 cleared and timeout_err[0]=1 exactly 8 cycles after grant; a beat at cycle 5 restarts the count.
//  T6 reset mid-packet:
//   - Stimulus: glb_reset during beat 2 of a 4-beat packet.
//   - Expect all sel=0 at the next edge, ptr=0, timeout_err=0.

Source files
------------

// File: rtl/xbar_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// xbar_port_arbiter_if
//   Bundles the request, observed-handshake, config and grant signals of the
//   4x4 cross bar port arbiter.
//   master : drives rx_req/rx_dest/rx_t*/cfg_out_en, observes grants
//   slave  : the arbiter; consumes requests, drives fifo_sel_bits_*, rx_grant,
//            out_busy, timeout_err
// Signals
//   rx_req      [3:0]  port i requests a FIFO
//   rx_dest     [7:0]  [2i+1:2i] destination FIFO of port i
//   rx_tvalid   [3:0]  per-port AXIS tvalid (observed)
//   rx_tready   [3:0]  per-port AXIS tready (observed)
//   rx_tlast    [3:0]  per-port AXIS tlast  (observed)
//   cfg_out_en  [3:0]  FIFO j may accept new grants
//   fifo_sel_bits_0..3 [3:0] one-hot owner port per FIFO, 0 = idle
//   rx_grant    [3:0]  port i owns some FIFO
//   out_busy    [3:0]  FIFO j owned
//   timeout_err [3:0]  FIFO j force-released by watchdog (1-cycle pulse)
// ----------------------------------------------------------------------------
interface xbar_port_arbiter_if;
    logic [3:0] rx_req;
    logic [7:0] rx_dest;
    logic [3:0] rx_tvalid;
    logic [3:0] rx_tready;
    logic [3:0] rx_tlast;
    logic [3:0] cfg_out_en;
    logic [3:0] fifo_sel_bits_0;
    logic [3:0] fifo_sel_bits_1;
    logic [3:0] fifo_sel_bits_2;
    logic [3:0] fifo_sel_bits_3;
    logic [3:0] rx_grant;
    logic [3:0] out_busy;
    logic [3:0] timeout_err;

    modport master (
        output rx_req, rx_dest, rx_tvalid, rx_tready, rx_tlast, cfg_out_en,
        input  fifo_sel_bits_0, fifo_sel_bits_1, fifo_sel_bits_2,
               fifo_sel_bits_3, rx_grant, out_busy, timeout_err
    );

    modport slave (
        input  rx_req, rx_dest, rx_tvalid, rx_tready, rx_tlast, cfg_out_en,
        output fifo_sel_bits_0, fifo_sel_bits_1, fifo_sel_bits_2,
               fifo_sel_bits_3, rx_grant, out_busy, timeout_err
    );
endinterface

// File: rtl/xbar_port_arbiter.sv
// ----------------------------------------------------------------------------
// xbar_port_arbiter
//   Per-output round-robin allocator driving the fifo_sel_bits_0..3 selects of
//   the 4x4 AXIS cross bar. Each FIFO runs its own IDLE/OWNED machine; a grant
//   is held until the owner's tlast beat is accepted, or until the watchdog
//   sees TIMEOUT consecutive owner cycles without an accepted beat.
// Parameters
//   TIMEOUT  stall cycles before forced release (0 disables the watchdog)
//   TO_W     watchdog counter width, must hold TIMEOUT
// Ports
//   glb_clk    rising-edge clock
//   glb_reset  synchronous, active-high reset
//   bus        xbar_port_arbiter_if.slave (requests in, selects/status out)
// ----------------------------------------------------------------------------
module xbar_port_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic                glb_clk,
    input  logic                glb_reset,
    xbar_port_arbiter_if.slave  bus
);
    localparam int NP = 4;
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    typedef enum logic {S_IDLE = 1'b0, S_OWNED = 1'b1} state_t;

    logic [NP-1:0][NP-1:0] w_sel;    // [fifo][port], registered owners
    logic [NP-1:0]         w_grant;
    logic [NP-1:0]         w_busy;
    logic [NP-1:0]         w_err;

    // A port owns at most one FIFO, so OR-ing the columns stays one bit per port.
    always_comb begin
        w_grant = '0;
        for (int j = 0; j < NP; j++) w_grant = w_grant | w_sel[j];
    end

    genvar gj;
    generate
        for (gj = 0; gj < NP; gj++) begin : g_fifo
            state_t          r_state, w_state_nxt;
            logic [NP-1:0]   r_sel, w_sel_nxt;
            logic [1:0]      r_ptr, w_ptr_nxt;
            logic [TO_W-1:0] r_cnt, w_cnt_nxt;
            logic            r_err, w_err_nxt;
            logic [NP-1:0]   w_cand;
            logic            w_found;
            logic [1:0]      w_win;
            logic            w_hs;
            logic            w_last;
            logic            w_wd;

            // Already-granted ports are excluded; since each port names a
            // single destination, two FIFOs can never pick the same port.
            always_comb begin
                w_cand = '0;
                for (int i = 0; i < NP; i++)
                    w_cand[i] = bus.rx_req[i] && (bus.rx_dest[2*i +: 2] == 2'(gj)) &&
                                !w_grant[i] && bus.cfg_out_en[gj];
            end

            // Search upward from the pointer; 2-bit index wraps 3->0.
            always_comb begin
                logic [1:0] idx;
                idx     = '0;
                w_found = 1'b0;
                w_win   = '0;
                for (int k = 0; k < NP; k++) begin
                    idx = r_ptr + 2'(k);
                    if (!w_found && w_cand[idx]) begin
                        w_found = 1'b1;
                        w_win   = idx;
                    end
                end
            end

            assign w_hs   = |(r_sel & bus.rx_tvalid & bus.rx_tready);
            assign w_last = |(r_sel & bus.rx_tvalid & bus.rx_tready & bus.rx_tlast);
            assign w_wd   = (TIMEOUT > 0) && !w_hs && (r_cnt == TO_LAST);

            always_comb begin
                w_state_nxt = r_state;
                w_sel_nxt   = r_sel;
                w_ptr_nxt   = r_ptr;
                w_cnt_nxt   = r_cnt;
                w_err_nxt   = 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (w_found) begin
                            w_state_nxt = S_OWNED;
                            w_sel_nxt   = NP'(1) << w_win;
                            w_ptr_nxt   = w_win + 2'd1;
                            w_cnt_nxt   = '0;
                        end
                    end
                    S_OWNED: begin
                        // tlast wins over the watchdog when both land together.
                        if (w_last) begin
                            w_state_nxt = S_IDLE;
                            w_sel_nxt   = '0;
                            w_cnt_nxt   = '0;
                        end else if (w_hs) begin
                            w_cnt_nxt   = '0;
                        end else if (w_wd) begin
                            w_state_nxt = S_IDLE;
                            w_sel_nxt   = '0;
                            w_cnt_nxt   = '0;
                            w_err_nxt   = 1'b1;
                        end else if (TIMEOUT > 0) begin
                            w_cnt_nxt   = r_cnt + TO_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                        w_sel_nxt   = '0;
                    end
                endcase
            end

            always_ff @(posedge glb_clk) begin
                if (glb_reset) begin
                    r_state <= S_IDLE;
                    r_sel   <= '0;
                    r_ptr   <= '0;
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_sel   <= w_sel_nxt;
                    r_ptr   <= w_ptr_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_err   <= w_err_nxt;
                end
            end

            assign w_sel[gj]  = r_sel;
            assign w_busy[gj] = |r_sel;
            assign w_err[gj]  = r_err;
        end
    endgenerate

    assign bus.fifo_sel_bits_0 = w_sel[0];
    assign bus.fifo_sel_bits_1 = w_sel[1];
    assign bus.fifo_sel_bits_2 = w_sel[2];
    assign bus.fifo_sel_bits_3 = w_sel[3];
    assign bus.rx_grant        = w_grant;
    assign bus.out_busy        = w_busy;
    assign bus.timeout_err     = w_err;

endmodule

// File: tb/tb_xbar_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_xbar_port_arbiter
//   Directed bench for xbar_port_arbiter with TIMEOUT=8. A per-FIFO owner
//   model (owner index, pointer, stall count) predicts every output and is
//   compared on each falling edge; directed literals pin the model itself.
// ----------------------------------------------------------------------------
module tb_xbar_port_arbiter;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;

    xbar_port_arbiter_if bus();

    xbar_port_arbiter #(.TIMEOUT(TO), .TO_W(4)) dut (
        .glb_clk   (clk),
        .glb_reset (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] sel(input int j);
        case (j)
            0:       return bus.fifo_sel_bits_0;
            1:       return bus.fifo_sel_bits_1;
            2:       return bus.fifo_sel_bits_2;
            default: return bus.fifo_sel_bits_3;
        endcase
    endfunction

    // ---------------- model: owner index per FIFO, -1 = free ----------------
    int m_owner[4] = '{-1, -1, -1, -1};
    int m_ptr[4]   = '{0, 0, 0, 0};
    int m_cnt[4]   = '{0, 0, 0, 0};
    bit m_err[4]   = '{0, 0, 0, 0};

    always @(posedge clk) begin : model
        bit taken[4];
        int p;
        int o;
        int d;
        bit hs;
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                m_owner[j] = -1; m_ptr[j] = 0; m_cnt[j] = 0; m_err[j] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) taken[i] = 0;
            for (int j = 0; j < 4; j++) if (m_owner[j] >= 0) taken[m_owner[j]] = 1;
            for (int j = 0; j < 4; j++) begin
                m_err[j] = 0;
                if (m_owner[j] < 0) begin
                    for (int k = 0; k < 4; k++) begin
                        p = (m_ptr[j] + k) % 4;
                        d = int'(bus.rx_dest[2*p +: 2]);
                        if (m_owner[j] < 0 && bus.rx_req[p] && d == j && !taken[p] && bus.cfg_out_en[j]) begin
                            m_owner[j] = p;
                            m_ptr[j]   = (p + 1) % 4;
                            m_cnt[j]   = 0;
                        end
                    end
                end else begin
                    o  = m_owner[j];
                    hs = bus.rx_tvalid[o] && bus.rx_tready[o];
                    if (hs && bus.rx_tlast[o]) begin
                        m_owner[j] = -1; m_cnt[j] = 0;
                    end else if (hs) begin
                        m_cnt[j] = 0;
                    end else if (TO > 0 && m_cnt[j] == TO - 1) begin
                        m_owner[j] = -1; m_cnt[j] = 0; m_err[j] = 1;
                    end else begin
                        m_cnt[j]++;
                    end
                end
            end
        end
    end

    // ---------------- compare against the model every cycle ----------------
    logic [3:0] es, eg, eb, ee;
    always @(negedge clk) begin
        if (chk_en) begin
            eg = '0; eb = '0; ee = '0;
            for (int j = 0; j < 4; j++) begin
                es = (m_owner[j] >= 0) ? 4'(1 << m_owner[j]) : 4'b0000;
                check($sformatf("model sel_%0d", j), {4'b0, sel(j)}, {4'b0, es});
                eg = eg | es;
                eb[j] = (es != 4'b0000);
                ee[j] = m_err[j];
            end
            check("model rx_grant", {4'b0, bus.rx_grant}, {4'b0, eg});
            check("model out_busy", {4'b0, bus.out_busy}, {4'b0, eb});
            check("model timeout_err", {4'b0, bus.timeout_err}, {4'b0, ee});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.rx_req = '0; bus.rx_tvalid = '0; bus.rx_tready = '0; bus.rx_tlast = '0;
    endtask

    // ---------------- directed stimulus ----------------
    logic [3:0] t3_exp [9];

    initial begin
        idle_in();
        bus.rx_dest    = '0;
        bus.cfg_out_en = 4'hF;

        // T1: reset with all ports requesting their own index
        bus.rx_req  = 4'hF;
        bus.rx_dest = 8'hE4;
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        for (int j = 0; j < 4; j++) check($sformatf("T1 rst sel_%0d", j), {4'b0, sel(j)}, 8'h00);
        check("T1 rst rx_grant", {4'b0, bus.rx_grant}, 8'h00);
        check("T1 rst out_busy", {4'b0, bus.out_busy}, 8'h00);
        check("T1 rst timeout_err", {4'b0, bus.timeout_err}, 8'h00);
        rst = 1'b0;
        step();
        check("T1 sel_0", {4'b0, sel(0)}, 8'h01);
        check("T1 sel_1", {4'b0, sel(1)}, 8'h02);
        check("T1 sel_2", {4'b0, sel(2)}, 8'h04);
        check("T1 sel_3", {4'b0, sel(3)}, 8'h08);
        check("T1 rx_grant", {4'b0, bus.rx_grant}, 8'h0F);
        bus.rx_req = '0;
        bus.rx_tvalid = 4'hF; bus.rx_tready = 4'hF; bus.rx_tlast = 4'hF;
        step();
        check("T1 release", {4'b0, bus.out_busy}, 8'h00);
        idle_in();
        step();

        // T2: port 2 -> FIFO 1, three beats
        bus.rx_dest = 8'h10;
        bus.rx_req  = 4'b0100;
        step();
        check("T2 sel_1 grant", {4'b0, sel(1)}, 8'h04);
        check("T2 rx_grant", {4'b0, bus.rx_grant}, 8'h04);
        bus.rx_req = '0;
        bus.rx_tvalid = 4'b0100; bus.rx_tready = 4'b0100;
        step();
        step();
        check("T2 sel_1 mid", {4'b0, sel(1)}, 8'h04);
        bus.rx_tlast = 4'b0100;
        step();
        check("T2 sel_1 after tlast", {4'b0, sel(1)}, 8'h00);
        idle_in();
        step();

        // T3: round robin on FIFO 0 among ports 0,1,3 from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        t3_exp = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h2};
        bus.rx_dest = 8'h00;
        bus.rx_req  = 4'b1011;
        bus.rx_tvalid = 4'b1011; bus.rx_tready = 4'b1011; bus.rx_tlast = 4'b1011;
        for (int k = 0; k < 9; k++) begin
            step();
            check($sformatf("T3 order %0d", k), {4'b0, sel(0)}, {4'b0, t3_exp[k]});
        end
        bus.rx_req = '0;
        step();
        check("T3 drain", {4'b0, sel(0)}, 8'h00);
        idle_in();
        step();

        // T4: parallel grants, then cfg_out_en[3] blocking
        bus.rx_dest = 8'h0E;
        bus.rx_req  = 4'b0011;
        step();
        check("T4 sel_2", {4'b0, sel(2)}, 8'h01);
        check("T4 sel_3", {4'b0, sel(3)}, 8'h02);
        bus.rx_req = '0;
        bus.rx_tvalid = 4'b0011; bus.rx_tready = 4'b0011; bus.rx_tlast = 4'b0011;
        step();
        check("T4 release", {4'b0, bus.out_busy}, 8'h00);
        idle_in();
        bus.cfg_out_en = 4'b0111;
        bus.rx_req = 4'b0011;
        step();
        check("T4 blk sel_2", {4'b0, sel(2)}, 8'h01);
        check("T4 blk sel_3", {4'b0, sel(3)}, 8'h00);
        check("T4 blk rx_grant", {4'b0, bus.rx_grant}, 8'h01);
        bus.rx_req = 4'b0010;
        step();
        check("T4 still blocked", {4'b0, sel(3)}, 8'h00);
        bus.cfg_out_en = 4'hF;
        step();
        check("T4 enabled sel_3", {4'b0, sel(3)}, 8'h02);
        bus.rx_req = '0;
        bus.cfg_out_en = 4'b0111;
        step();
        check("T4 disable keeps owner", {4'b0, sel(3)}, 8'h02);
        bus.rx_tvalid = 4'b0011; bus.rx_tready = 4'b0011; bus.rx_tlast = 4'b0011;
        step();
        check("T4 final release", {4'b0, bus.out_busy}, 8'h00);
        idle_in();
        bus.cfg_out_en = 4'hF;
        step();

        // T5a: port 3 -> FIFO 0 stalls; watchdog fires 8 edges after grant
        bus.rx_dest = 8'h00;
        bus.rx_req  = 4'b1000;
        step();
        check("T5 grant", {4'b0, sel(0)}, 8'h08);
        bus.rx_req = '0;
        for (int k = 1; k < 8; k++) begin
            step();
            check($sformatf("T5 held %0d", k), {4'b0, sel(0)}, 8'h08);
        end
        step();
        check("T5 wd sel_0", {4'b0, sel(0)}, 8'h00);
        check("T5 wd err", {4'b0, bus.timeout_err}, 8'h01);
        step();
        check("T5 err pulse ends", {4'b0, bus.timeout_err}, 8'h00);

        // T5b: a beat in cycle 5 restarts the count -> release at edge 13
        bus.rx_req = 4'b1000;
        step();
        bus.rx_req = '0;
        repeat (4) step();
        bus.rx_tvalid = 4'b1000; bus.rx_tready = 4'b1000;
        step();
        idle_in();
        for (int k = 6; k < 13; k++) begin
            step();
            check($sformatf("T5b held %0d", k), {4'b0, sel(0)}, 8'h08);
        end
        step();
        check("T5b wd sel_0", {4'b0, sel(0)}, 8'h00);
        check("T5b wd err", {4'b0, bus.timeout_err}, 8'h01);
        step();

        // T5c: tlast on the watchdog's last cycle is a normal release
        bus.rx_req = 4'b1000;
        step();
        bus.rx_req = '0;
        repeat (7) step();
        bus.rx_tvalid = 4'b1000; bus.rx_tready = 4'b1000; bus.rx_tlast = 4'b1000;
        step();
        check("T5c sel_0", {4'b0, sel(0)}, 8'h00);
        check("T5c no err", {4'b0, bus.timeout_err}, 8'h00);
        idle_in();
        step();

        // T6: reset during beat 2 of a port 1 -> FIFO 2 packet
        bus.rx_dest = 8'h08;
        bus.rx_req  = 4'b0010;
        step();
        check("T6 grant", {4'b0, sel(2)}, 8'h02);
        bus.rx_req = '0;
        bus.rx_tvalid = 4'b0010; bus.rx_tready = 4'b0010;
        step();
        rst = 1'b1;
        step();
        for (int j = 0; j < 4; j++) check($sformatf("T6 rst sel_%0d", j), {4'b0, sel(j)}, 8'h00);
        check("T6 rst err", {4'b0, bus.timeout_err}, 8'h00);
        rst = 1'b0;
        idle_in();
        // ports 0 and 3 race for FIFO 2: pointer back at 0 makes port 0 win
        bus.rx_dest = 8'h82;
        bus.rx_req  = 4'b1001;
        step();
        check("T6 ptr reset", {4'b0, sel(2)}, 8'h01);
        bus.rx_req = '0;
        bus.rx_tvalid = 4'b0001; bus.rx_tready = 4'b0001; bus.rx_tlast = 4'b0001;
        step();
        idle_in();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
